// File: rtl/rs_issue_queue_if.sv
// rs_issue_queue_if: dispatch, wakeup, issue and flush signals of one reservation station
// Ports (grouped here): flush; disp_* dispatch handshake and operands; wk_* wakeup broadcasts;
// iss_* issue handshake and selected uop; occupancy. master = upstream/FU side, slave = the queue.
interface rs_issue_queue_if #(
    parameter int PREG_W     = 6,
    parameter int PAYLOAD_W  = 32,
    parameter int NUM_WAKEUP = 2,
    parameter int OCC_W      = 4
);
    logic                         flush;
    logic                         disp_valid;
    logic                         disp_ready;
    logic [PREG_W-1:0]            disp_src1_preg;
    logic                         disp_src1_rdy;
    logic [PREG_W-1:0]            disp_src2_preg;
    logic                         disp_src2_rdy;
    logic [PREG_W-1:0]            disp_dst_preg;
    logic [PAYLOAD_W-1:0]         disp_payload;
    logic [NUM_WAKEUP-1:0]        wk_valid;
    logic [NUM_WAKEUP*PREG_W-1:0] wk_preg;
    logic                         iss_valid;
    logic                         iss_ready;
    logic [PREG_W-1:0]            iss_src1_preg;
    logic [PREG_W-1:0]            iss_src2_preg;
    logic [PREG_W-1:0]            iss_dst_preg;
    logic [PAYLOAD_W-1:0]         iss_payload;
    logic [OCC_W-1:0]             occupancy;
    modport master (
        output flush, disp_valid, disp_src1_preg, disp_src1_rdy, disp_src2_preg, disp_src2_rdy,
               disp_dst_preg, disp_payload, wk_valid, wk_preg, iss_ready,
        input  disp_ready, iss_valid, iss_src1_preg, iss_src2_preg, iss_dst_preg, iss_payload, occupancy
    );
    modport slave (
        input  flush, disp_valid, disp_src1_preg, disp_src1_rdy, disp_src2_preg, disp_src2_rdy,
               disp_dst_preg, disp_payload, wk_valid, wk_preg, iss_ready,
        output disp_ready, iss_valid, iss_src1_preg, iss_src2_preg, iss_dst_preg, iss_payload, occupancy
    );
endinterface

// File: rtl/rs_issue_queue.sv
// rs_issue_queue: reservation station holding uops until both sources are ready, issuing oldest ready first
// Ports: clk, rst (sync, active-high); bus (rs_issue_queue_if.slave) carries flush, dispatch,
// wakeup broadcasts, issue handshake and occupancy.
// Option: define RS_WAKE_SELECT_BYPASS_EN for zero-cycle wakeup-to-select.
module rs_issue_queue #(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_PREGS  = 64,
    parameter int NUM_WAKEUP = 2,
    parameter int PAYLOAD_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    rs_issue_queue_if.slave   bus
);
    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int OCC_W  = $clog2(RS_ENTRIES + 1);
    localparam int IDX_W  = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;
    logic [RS_ENTRIES-1:0] r_valid;
    logic [RS_ENTRIES-1:0] r_s1_rdy;
    logic [RS_ENTRIES-1:0] r_s2_rdy;
    logic [PREG_W-1:0]     r_s1  [RS_ENTRIES];
    logic [PREG_W-1:0]     r_s2  [RS_ENTRIES];
    logic [PREG_W-1:0]     r_dst [RS_ENTRIES];
    logic [PAYLOAD_W-1:0]  r_pay [RS_ENTRIES];
    // r_older[i][j] set means entry j was dispatched before entry i
    logic [RS_ENTRIES-1:0] r_older [RS_ENTRIES];
    logic [OCC_W-1:0]      r_occ;
    logic [RS_ENTRIES-1:0] w_hit1;
    logic [RS_ENTRIES-1:0] w_hit2;
    logic [RS_ENTRIES-1:0] w_elig;
    logic [RS_ENTRIES-1:0] w_sel;
    logic                  w_dhit1;
    logic                  w_dhit2;
    logic                  w_disp_fire;
    logic                  w_iss_fire;
    logic [IDX_W-1:0]      w_free;
    logic [PREG_W-1:0]     w_iss_s1;
    logic [PREG_W-1:0]     w_iss_s2;
    logic [PREG_W-1:0]     w_iss_dst;
    logic [PAYLOAD_W-1:0]  w_iss_pay;
    always_comb begin
        w_hit1  = '0;
        w_hit2  = '0;
        w_dhit1 = 1'b0;
        w_dhit2 = 1'b0;
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                w_hit1[i] = w_hit1[i] | (bus.wk_valid[k] && bus.wk_preg[k*PREG_W +: PREG_W] == r_s1[i]);
                w_hit2[i] = w_hit2[i] | (bus.wk_valid[k] && bus.wk_preg[k*PREG_W +: PREG_W] == r_s2[i]);
            end
            w_dhit1 = w_dhit1 | (bus.wk_valid[k] && bus.wk_preg[k*PREG_W +: PREG_W] == bus.disp_src1_preg);
            w_dhit2 = w_dhit2 | (bus.wk_valid[k] && bus.wk_preg[k*PREG_W +: PREG_W] == bus.disp_src2_preg);
        end
    end
`ifdef RS_WAKE_SELECT_BYPASS_EN
    assign w_elig = r_valid & (r_s1_rdy | w_hit1) & (r_s2_rdy | w_hit2);
`else
    assign w_elig = r_valid & r_s1_rdy & r_s2_rdy;
`endif
    // An eligible entry wins when no older entry is also eligible; ages form a total order, so one winner
    always_comb begin
        w_sel     = '0;
        w_iss_s1  = '0;
        w_iss_s2  = '0;
        w_iss_dst = '0;
        w_iss_pay = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_sel[i]  = w_elig[i] && ~|(r_older[i] & w_elig);
            w_iss_s1  = w_iss_s1  | (w_sel[i] ? r_s1[i]  : '0);
            w_iss_s2  = w_iss_s2  | (w_sel[i] ? r_s2[i]  : '0);
            w_iss_dst = w_iss_dst | (w_sel[i] ? r_dst[i] : '0);
            w_iss_pay = w_iss_pay | (w_sel[i] ? r_pay[i] : '0);
        end
    end
    always_comb begin
        w_free = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--)
            if (!r_valid[i]) w_free = IDX_W'(i);
    end
    assign bus.disp_ready    = r_occ < OCC_W'(RS_ENTRIES);
    assign bus.iss_valid     = |w_elig;
    assign bus.iss_src1_preg = w_iss_s1;
    assign bus.iss_src2_preg = w_iss_s2;
    assign bus.iss_dst_preg  = w_iss_dst;
    assign bus.iss_payload   = w_iss_pay;
    assign bus.occupancy     = r_occ;
    assign w_disp_fire       = bus.disp_valid && bus.disp_ready;
    assign w_iss_fire        = bus.iss_valid && bus.iss_ready;
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) r_older[i] <= '0;
        end else begin
            r_s1_rdy <= r_s1_rdy | w_hit1;
            r_s2_rdy <= r_s2_rdy | w_hit2;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_iss_fire && w_sel[i]) begin
                    r_valid[i] <= 1'b0;
                    r_older[i] <= '0;
                    for (int j = 0; j < RS_ENTRIES; j++) r_older[j][i] <= 1'b0;
                end
            end
            if (w_disp_fire) begin
                r_valid[w_free]  <= 1'b1;
                r_s1_rdy[w_free] <= bus.disp_src1_rdy | w_dhit1;
                r_s2_rdy[w_free] <= bus.disp_src2_rdy | w_dhit2;
                r_s1[w_free]     <= bus.disp_src1_preg;
                r_s2[w_free]     <= bus.disp_src2_preg;
                r_dst[w_free]    <= bus.disp_dst_preg;
                r_pay[w_free]    <= bus.disp_payload;
                // the new uop is younger than every survivor, excluding the one leaving this edge
                r_older[w_free]  <= r_valid & ~(w_iss_fire ? w_sel : '0);
                for (int j = 0; j < RS_ENTRIES; j++) r_older[j][w_free] <= 1'b0;
            end
            r_occ <= r_occ + OCC_W'(w_disp_fire) - OCC_W'(w_iss_fire);
        end
    end
endmodule
